// File: rtl/ptb2_axi_pkg.sv
// Shared definitions for the PTB2 AXI4-Lite master sequencer: slave register offsets,
// response and result codes, and the sequencer state encoding.
package ptb2_axi_pkg;

  localparam logic [31:0] OFF_A        = 32'h00;
  localparam logic [31:0] OFF_B        = 32'h04;
  localparam logic [31:0] OFF_C        = 32'h08;
  localparam logic [31:0] OFF_READ_EN  = 32'h0C;
  localparam logic [31:0] OFF_RESULT   = 32'h10;
  localparam logic [31:0] OFF_DATA_OUT = 32'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_ONE     = 2'b01;
  localparam logic [1:0] RES_TWO     = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_C,
    ST_SETTLE,
    ST_RD_RES,
    ST_EN_WR,
    ST_RD_ROOT,
    ST_RESP
  } seq_state_t;

  function automatic logic [31:0] sext5(input logic [4:0] v);
    return {{27{v[4]}}, v};
  endfunction

endpackage

// File: rtl/ptb2_axi_lite_single_xfer.sv
// One-shot single-beat AXI4-Lite write/read engine; done pulses on the B or R handshake.
// Optional watchdog enabled by PTB2_MST_TIMEOUT_EN.
module ptb2_axi_lite_single_xfer
`ifdef PTB2_MST_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic        o_timeout,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  logic [31:0] r_awaddr, r_araddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic        w_b_hs, w_r_hs, w_timeout;

  assign w_b_hs = i_bvalid && r_bready;
  assign w_r_hs = i_rvalid && r_rready;

`ifdef PTB2_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_busy;

  assign w_busy = r_awvalid || r_wvalid || r_bready || r_arvalid || r_rready;

  // Reloaded on every issue; expiry fires only if the closing handshake is absent.
  always_ff @(posedge clk) begin
    if (rst)
      r_tmo_cnt <= '0;
    else if (i_start)
      r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (w_busy && r_tmo_cnt != '0)
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
  end

  assign w_timeout = w_busy && (r_tmo_cnt == '0) && !w_b_hs && !w_r_hs;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else if (i_start) begin
      if (i_write) begin
        r_awaddr  <= i_addr;
        r_wdata   <= i_wdata;
        r_wstrb   <= 4'hF;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_bready  <= 1'b1;
      end else begin
        r_araddr  <= i_addr;
        r_arvalid <= 1'b1;
        r_rready  <= 1'b1;
      end
    end else if (w_timeout) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      if (r_awvalid && i_awready) r_awvalid <= 1'b0;
      if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
      if (w_b_hs)                 r_bready  <= 1'b0;
      if (r_arvalid && i_arready) r_arvalid <= 1'b0;
      if (w_r_hs)                 r_rready  <= 1'b0;
    end
  end

  assign o_done    = w_b_hs || w_r_hs || w_timeout;
  assign o_timeout = w_timeout;
  assign o_resp    = w_b_hs ? i_bresp : (w_r_hs ? i_rresp : 2'b00);
  assign o_rdata   = i_rdata;

  assign o_awaddr  = r_awaddr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_araddr  = r_araddr;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

endmodule

// File: rtl/ptb2_axi4_lite_master_seq.sv
// AXI4-Lite master sequencer feeding the PTB2 quadratic-solver slave from a command stream.
// Optional per-handshake watchdog enabled by PTB2_MST_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a coefficient triple
// WR_A/B/C   | writing coefficient a / b / c
// SETTLE     | counting SETTLE_CYCLES before polling the result
// RD_RES     | reading RESULT
// EN_WR      | writing 1 to READ_EN to present the next root
// RD_ROOT    | reading DATA_OUT
// RESP       | rsp_valid held until rsp_ready
module ptb2_axi4_lite_master_seq
  import ptb2_axi_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR   = 32'h79C00000,
  parameter int          SETTLE_CYCLES = 5
`ifdef PTB2_MST_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 1024
`endif
)
(
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_a,
  input  logic [4:0]  cmd_b,
  input  logic [4:0]  cmd_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_result,
  output logic [3:0]  rsp_x1,
  output logic [3:0]  rsp_x2,
  output logic        rsp_err,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  seq_state_t  r_state, w_next;
  logic [4:0]  r_a, r_b, r_c;
  logic [1:0]  r_result;
  logic [3:0]  r_x1, r_x2;
  logic        r_err, r_issued, r_root_sel;
  logic [7:0]  r_settle_cnt;

  logic        w_start, w_write, w_done, w_timeout, w_xfer_err, w_cmd_hs;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic [1:0]  w_resp;
  logic        w_unused_rdata;

  assign w_cmd_hs       = cmd_valid && (r_state == ST_IDLE);
  assign w_xfer_err     = w_done && ((w_resp != RESP_OKAY) || w_timeout);
  assign w_unused_rdata = ^w_rdata[31:4];

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_write = 1'b0;
    w_addr  = C_BASE_ADDR;
    w_wdata = '0;
    unique case (r_state)
      ST_IDLE: if (cmd_valid) w_next = ST_WR_A;
      ST_WR_A: begin
        w_start = !r_issued;
        w_write = 1'b1;
        w_addr  = C_BASE_ADDR + OFF_A;
        w_wdata = sext5(r_a);
        if (w_done) w_next = w_xfer_err ? ST_RESP : ST_WR_B;
      end
      ST_WR_B: begin
        w_start = !r_issued;
        w_write = 1'b1;
        w_addr  = C_BASE_ADDR + OFF_B;
        w_wdata = sext5(r_b);
        if (w_done) w_next = w_xfer_err ? ST_RESP : ST_WR_C;
      end
      ST_WR_C: begin
        w_start = !r_issued;
        w_write = 1'b1;
        w_addr  = C_BASE_ADDR + OFF_C;
        w_wdata = sext5(r_c);
        if (w_done) w_next = w_xfer_err ? ST_RESP : ST_SETTLE;
      end
      ST_SETTLE: if (r_settle_cnt == '0) w_next = ST_RD_RES;
      ST_RD_RES: begin
        w_start = !r_issued;
        w_addr  = C_BASE_ADDR + OFF_RESULT;
        if (w_done) begin
          if (w_xfer_err)
            w_next = ST_RESP;
          else if (w_rdata[1:0] == RES_TWO || w_rdata[1:0] == RES_ONE)
            w_next = ST_EN_WR;
          else
            w_next = ST_RESP;
        end
      end
      ST_EN_WR: begin
        w_start = !r_issued;
        w_write = 1'b1;
        w_addr  = C_BASE_ADDR + OFF_READ_EN;
        w_wdata = 32'h1;
        if (w_done) w_next = w_xfer_err ? ST_RESP : ST_RD_ROOT;
      end
      ST_RD_ROOT: begin
        w_start = !r_issued;
        w_addr  = C_BASE_ADDR + OFF_DATA_OUT;
        if (w_done) begin
          if (!w_xfer_err && r_result == RES_TWO && !r_root_sel)
            w_next = ST_EN_WR;
          else
            w_next = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_result     <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_err        <= 1'b0;
      r_issued     <= 1'b0;
      r_root_sel   <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start)     r_issued <= 1'b1;
      else if (w_done) r_issued <= 1'b0;
      // Roots are cleared per command so anything not collected reads back as 0.
      if (w_cmd_hs) begin
        r_a        <= cmd_a;
        r_b        <= cmd_b;
        r_c        <= cmd_c;
        r_result   <= '0;
        r_x1       <= '0;
        r_x2       <= '0;
        r_err      <= 1'b0;
        r_root_sel <= 1'b0;
      end
      if (r_state == ST_WR_C && w_done)
        r_settle_cnt <= 8'(SETTLE_CYCLES - 1);
      else if (r_state == ST_SETTLE && r_settle_cnt != '0)
        r_settle_cnt <= r_settle_cnt - 1'b1;
      if (w_xfer_err) r_err <= 1'b1;
      if (r_state == ST_RD_RES && w_done && !w_xfer_err)
        r_result <= w_rdata[1:0];
      if (r_state == ST_RD_ROOT && w_done && !w_xfer_err) begin
        if (!r_root_sel) begin
          r_x1 <= w_rdata[3:0];
          if (r_result == RES_ONE) r_x2 <= w_rdata[3:0];
        end else begin
          r_x2 <= w_rdata[3:0];
        end
        r_root_sel <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_result = r_result;
  assign rsp_x1     = r_x1;
  assign rsp_x2     = r_x2;
  assign rsp_err    = r_err;

  ptb2_axi_lite_single_xfer
`ifdef PTB2_MST_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_xfer (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .i_start   (w_start),
    .i_write   (w_write),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_resp    (w_resp),
    .o_rdata   (w_rdata),
    .o_awaddr  (M_AXI_AWADDR),
    .o_awvalid (M_AXI_AWVALID),
    .i_awready (M_AXI_AWREADY),
    .o_wdata   (M_AXI_WDATA),
    .o_wstrb   (M_AXI_WSTRB),
    .o_wvalid  (M_AXI_WVALID),
    .i_wready  (M_AXI_WREADY),
    .i_bresp   (M_AXI_BRESP),
    .i_bvalid  (M_AXI_BVALID),
    .o_bready  (M_AXI_BREADY),
    .o_araddr  (M_AXI_ARADDR),
    .o_arvalid (M_AXI_ARVALID),
    .i_arready (M_AXI_ARREADY),
    .i_rdata   (M_AXI_RDATA),
    .i_rresp   (M_AXI_RRESP),
    .i_rvalid  (M_AXI_RVALID),
    .o_rready  (M_AXI_RREADY)
  );

endmodule

// File: tb/tb_ptb2_axi4_lite_master_seq.sv
// Directed bench for ptb2_axi4_lite_master_seq with a behavioural solver slave,
// a response scoreboard and a handshake-stability monitor.
module tb_ptb2_axi4_lite_master_seq;
  import ptb2_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h79C00000;

  typedef struct {
    logic [1:0] result;
    logic [3:0] x1;
    logic [3:0] x2;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [4:0]  cmd_a = '0, cmd_b = '0, cmd_c = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [1:0]  rsp_result;
  logic [3:0]  rsp_x1, rsp_x2;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int n_total = 0, n_pass = 0, n_fail = 0, prot_err = 0;

  // slave configuration, written by the stimulus
  logic        cfg_rand = 1'b0;
  logic [1:0]  cfg_result = RES_NONE;
  logic [3:0]  cfg_x1 = '0, cfg_x2 = '0;
  logic [31:0] cfg_err_off = 32'hFFFF_FFFF;

  logic [63:0] wr_log[$], exp_wr[$];
  logic [31:0] rd_log[$], exp_rd[$];
  exp_t        sb[$];

  always #5 clk = ~clk;

  ptb2_axi4_lite_master_seq dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_x1(rsp_x1), .rsp_x2(rsp_x2), .rsp_err(rsp_err),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(m_rready)
  );

  // ---------------- behavioural slave (decisions at negedge) ----------------
  logic        s_got_aw, s_got_w, s_got_ar, s_p_aw, s_p_w, s_p_b, s_p_ar, s_p_r;
  logic [31:0] s_aw_addr, s_w_data, s_ar_addr;
  int          s_aw_dly, s_w_dly, s_b_dly, s_ar_dly, s_r_dly, s_en_cnt;

  task automatic new_wdelays();
    if (cfg_rand) begin
      s_aw_dly = int'($urandom_range(0, 7));
      s_w_dly  = (s_aw_dly + 1 + int'($urandom_range(0, 6))) % 8;
      s_b_dly  = int'($urandom_range(0, 7));
    end else begin
      s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0;
    end
  endtask

  task automatic new_rdelays();
    s_ar_dly = cfg_rand ? int'($urandom_range(0, 7)) : 0;
    s_r_dly  = cfg_rand ? int'($urandom_range(0, 7)) : 0;
  endtask

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    s_got_aw = 0; s_got_w = 0; s_got_ar = 0;
    s_p_aw = 0; s_p_w = 0; s_p_b = 0; s_p_ar = 0; s_p_r = 0;
    s_aw_addr = '0; s_w_data = '0; s_ar_addr = '0; s_en_cnt = 0;
    new_wdelays();
    new_rdelays();
  endtask

  initial begin
    logic [31:0] off;
    logic [3:0]  root;
    slave_clear();
    forever begin
      @(negedge clk);
      if (areset) begin
        slave_clear();
      end else begin
        if (s_p_aw) begin s_got_aw = 1; s_p_aw = 0; awready = 0; end
        if (s_p_w)  begin s_got_w  = 1; s_p_w  = 0; wready  = 0; end
        if (s_p_b)  begin s_p_b = 0; bvalid = 0; s_got_aw = 0; s_got_w = 0; new_wdelays(); end
        if (s_p_ar) begin s_got_ar = 1; s_p_ar = 0; arready = 0; end
        if (s_p_r)  begin s_p_r = 0; rvalid = 0; s_got_ar = 0; new_rdelays(); end

        if (m_awvalid && !s_got_aw && !awready) begin
          if (s_aw_dly == 0) awready = 1; else s_aw_dly--;
        end
        if (awready && m_awvalid) begin s_p_aw = 1; s_aw_addr = m_awaddr; end
        if (m_wvalid && !s_got_w && !wready) begin
          if (s_w_dly == 0) wready = 1; else s_w_dly--;
        end
        if (wready && m_wvalid) begin s_p_w = 1; s_w_data = m_wdata; end

        if (s_got_aw && s_got_w && !bvalid) begin
          if (s_b_dly == 0) begin
            off    = s_aw_addr - BASE;
            bvalid = 1;
            bresp  = (off == cfg_err_off) ? RESP_SLVERR : RESP_OKAY;
            wr_log.push_back({s_aw_addr, s_w_data});
            if (off == OFF_A)       s_en_cnt = 0;
            if (off == OFF_READ_EN) s_en_cnt++;
          end else s_b_dly--;
        end
        if (bvalid && m_bready) s_p_b = 1;

        if (m_arvalid && !s_got_ar && !arready) begin
          if (s_ar_dly == 0) arready = 1; else s_ar_dly--;
        end
        if (arready && m_arvalid) begin s_p_ar = 1; s_ar_addr = m_araddr; end
        if (s_got_ar && !rvalid) begin
          if (s_r_dly == 0) begin
            off    = s_ar_addr - BASE;
            root   = (s_en_cnt <= 1) ? cfg_x1 : cfg_x2;
            rvalid = 1;
            rresp  = RESP_OKAY;
            rd_log.push_back(s_ar_addr);
            if (off == OFF_RESULT)        rdata = {30'b0, cfg_result};
            else if (off == OFF_DATA_OUT) rdata = {{28{root[3]}}, root};
            else                          rdata = 32'hDEAD_BEEF;
          end else s_r_dly--;
        end
        if (rvalid && m_rready) s_p_r = 1;
      end
    end
  end

  // ---------------- handshake stability / exclusivity monitor ----------------
  logic        pc_ok = 0, pc_aw = 0, pc_awr = 0, pc_w = 0, pc_wr = 0, pc_ar = 0, pc_arr = 0;
  logic        pc_rv = 0, pc_rr = 0;
  logic [31:0] pc_awaddr = '0, pc_wdata = '0, pc_araddr = '0;
  logic [10:0] pc_rsp = '0;

  always @(posedge clk) begin
    if (pc_ok) begin
      if (pc_aw && !pc_awr && (!m_awvalid || m_awaddr != pc_awaddr)) prot_err++;
      if (pc_w && !pc_wr && (!m_wvalid || m_wdata != pc_wdata))      prot_err++;
      if (pc_ar && !pc_arr && (!m_arvalid || m_araddr != pc_araddr)) prot_err++;
      if (pc_rv && !pc_rr && (!rsp_valid || {rsp_result, rsp_x1, rsp_x2, rsp_err} != pc_rsp)) prot_err++;
    end
    if ((m_awvalid || m_wvalid || m_bready) && (m_arvalid || m_rready)) prot_err++;
    if (m_wvalid && m_wstrb != 4'hF) prot_err++;
    pc_ok = !areset;
    pc_aw = m_awvalid; pc_awr = awready; pc_awaddr = m_awaddr;
    pc_w  = m_wvalid;  pc_wr  = wready;  pc_wdata  = m_wdata;
    pc_ar = m_arvalid; pc_arr = arready; pc_araddr = m_araddr;
    pc_rv = rsp_valid; pc_rr  = rsp_ready;
    pc_rsp = {rsp_result, rsp_x1, rsp_x2, rsp_err};
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [31:0] off, input logic [31:0] data);
    exp_wr.push_back({BASE + off, data});
  endtask

  task automatic exp_read(input logic [31:0] off);
    exp_rd.push_back(BASE + off);
  endtask

  task automatic send_cmd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                          input exp_t e);
    int n = 0;
    sb.push_back(e);
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_valid = 1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    while (!rsp_valid && n < 5000) begin tick(); n++; end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_rsp_held"}, 32'(rsp_valid), 32'd1);
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(rsp_result), 32'(e.result));
      check({tag, "_x1"},     32'(rsp_x1),     32'(e.x1));
      check({tag, "_x2"},     32'(rsp_x2),     32'(e.x2));
      check({tag, "_err"},    32'(rsp_err),    32'(e.err));
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check({tag, "_idle"}, 32'({cmd_ready, rsp_valid}), 32'b10);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check({tag, "_waddr"}, wr_log[i][63:32], exp_wr[i][63:32]);
      check({tag, "_wdata"}, wr_log[i][31:0],  exp_wr[i][31:0]);
    end
    check({tag, "_nrd"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check({tag, "_raddr"}, rd_log[i], exp_rd[i]);
    wr_log.delete(); exp_wr.delete(); rd_log.delete(); exp_rd.delete();
  endtask

  task automatic run_two_roots(input string tag);
    cfg_result = RES_TWO; cfg_x1 = 4'd2; cfg_x2 = 4'hD;
    exp_write(OFF_A, 32'h1); exp_write(OFF_B, 32'h1); exp_write(OFF_C, 32'hFFFF_FFFA);
    exp_read(OFF_RESULT);
    exp_write(OFF_READ_EN, 32'h1); exp_read(OFF_DATA_OUT);
    exp_write(OFF_READ_EN, 32'h1); exp_read(OFF_DATA_OUT);
    send_cmd(5'd1, 5'd1, 5'b11010, '{RES_TWO, 4'd2, 4'hD, 1'b0});
    get_rsp(tag, 0);
    compare_logs(tag);
  endtask

  task automatic run_one_root(input string tag);
    cfg_result = RES_ONE; cfg_x1 = 4'hF; cfg_x2 = 4'h0;
    exp_write(OFF_A, 32'h1); exp_write(OFF_B, 32'h2); exp_write(OFF_C, 32'h1);
    exp_read(OFF_RESULT);
    exp_write(OFF_READ_EN, 32'h1); exp_read(OFF_DATA_OUT);
    send_cmd(5'd1, 5'd2, 5'd1, '{RES_ONE, 4'hF, 4'hF, 1'b0});
    get_rsp(tag, 0);
    compare_logs(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (5) tick();
    areset = 0;
    tick();
    check("rst_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wstrb", 32'(m_wstrb), 32'd0);
    check("rst_addr_data", m_awaddr | m_araddr | m_wdata, 32'd0);

    run_one_root("t1");
    run_two_roots("t2");

    // no roots: RESULT 00 and the invalid code 11
    cfg_result = RES_NONE;
    exp_write(OFF_A, 32'h2); exp_write(OFF_B, 32'h1); exp_write(OFF_C, 32'h3);
    exp_read(OFF_RESULT);
    send_cmd(5'd2, 5'd1, 5'd3, '{RES_NONE, 4'd0, 4'd0, 1'b0});
    get_rsp("t3a", 0);
    compare_logs("t3a");
    cfg_result = RES_INVALID;
    exp_write(OFF_A, 32'h3); exp_write(OFF_B, 32'h0); exp_write(OFF_C, 32'hFFFF_FFF0);
    exp_read(OFF_RESULT);
    send_cmd(5'd3, 5'd0, 5'b10000, '{RES_INVALID, 4'd0, 4'd0, 1'b0});
    get_rsp("t3b", 0);
    compare_logs("t3b");

    cfg_rand = 1;
    for (int k = 0; k < 3; k++) begin
      run_two_roots("t4_two");
      run_one_root("t4_one");
    end
    cfg_rand = 0;
    check("t4_protocol", 32'(prot_err), 32'd0);

    // slave error on the B write: no C write, no reads
    cfg_err_off = OFF_B; cfg_result = RES_TWO;
    exp_write(OFF_A, 32'h1); exp_write(OFF_B, 32'h2);
    send_cmd(5'd1, 5'd2, 5'd1, '{RES_NONE, 4'd0, 4'd0, 1'b1});
    get_rsp("t5", 3);
    compare_logs("t5");
    cfg_err_off = 32'hFFFF_FFFF;

    // reset while the first DATA_OUT read is outstanding
    cfg_result = RES_TWO; cfg_x1 = 4'd2; cfg_x2 = 4'hD;
    send_cmd(5'd1, 5'd1, 5'b11010, '{RES_TWO, 4'd2, 4'hD, 1'b0});
    n = 0;
    while (!(m_arvalid && m_araddr == BASE + OFF_DATA_OUT) && n < 2000) begin tick(); n++; end
    check("t6_reached_rd_root", 32'(m_arvalid), 32'd1);
    areset = 1;
    tick();
    areset = 0;
    check("t6_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.delete(); wr_log.delete(); rd_log.delete(); exp_wr.delete(); exp_rd.delete();
    tick();
    run_one_root("t6_fresh");

    check("protocol", 32'(prot_err), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ptb2_axi4_lite_master_seq.md
Name: ptb2_axi4_lite_master_seq

Overview:
AXI4-Lite master sequencer that sits directly upstream of the PTB2 quadratic-solver slave and drives its register map.
- Accepts one coefficient triple (a, b, c) per command over a valid/ready interface.
- Writes the coefficients to the slave, waits, then reads the result code.
- Pulses READ_EN and reads DATA_OUT once per root, then returns the result code and roots on a valid/ready response interface.
- Replaces software/testbench-driven register sequencing so the solver can be fed from fabric logic.

Parameters:
C_BASE_ADDR, 32'h79C00000, slave base address. Register offsets: A 0x00, B 0x04, C 0x08, READ_EN 0x0C, RESULT 0x10, DATA_OUT 0x14.
SETTLE_CYCLES, 5, idle cycles between the B response of the C write and issuing the RESULT read (1..255).
TIMEOUT_CYCLES, 1024, per-handshake watchdog limit; used only with the optional feature.

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  reset, synchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_a / cmd_b / cmd_c  in  5 each  signed coefficients
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_result  out  2  RESULT[1:0] from slave
rsp_x1 / rsp_x2  out  4 each  signed roots, DATA_OUT[3:0]
rsp_err  out  1  SLVERR/DECERR seen (or timeout)
M_AXI_AWADDR out 32; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1
M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
M_AXI_ARADDR out 32; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
Reset values:
- All VALID/READY outputs, rsp_*, addresses and WDATA are 0; WSTRB is 0; state is IDLE.
- Reset mid-transaction aborts at the next edge; the slave is reset in the same domain.

Command capture:
- Occurs on cmd_valid && cmd_ready; coefficients are registered.

State sequence:
IDLE -> WR_A -> WR_B -> WR_C -> SETTLE -> RD_RES -> {EN_WR -> RD_ROOT} x N -> RESP -> IDLE.

Write phase (WR_*, EN_WR):
- AWVALID and WVALID rise together.
- Each drops independently after its own handshake.
- BREADY is high from issue until the B handshake; the state advances on the B handshake.
- Coefficient WDATA is the coefficient sign-extended to 32 bits; WSTRB is 4'hF.
- The EN_WR write data is 32'h1.

Read phase (RD_*):
- ARVALID is held until ARREADY; RREADY is high until the R handshake.
- RDATA is captured on RVALID && RREADY.
- No VALID deasserts before its READY.

Outstanding transactions:
- At most one outstanding transaction; write and read are never concurrent.

Root count N from RESULT:
- 2'b10 -> 2 roots.
- 2'b01 -> 1 root; x2 = x1.
- 2'b00 or 2'b11 -> 0 roots; x1 = x2 = 0.

SETTLE:
- Counts SETTLE_CYCLES clocks, then issues the RESULT read.

Error handling:
- Any BRESP or RRESP other than 2'b00 sets rsp_err.
- The current handshake completes, then the block skips to RESP.
- Uncollected roots are reported as 0.

Response:
- rsp_valid is held with stable data until rsp_ready.
- cmd_ready stays 0 until the response is accepted; back-to-back commands are therefore serialized.
- rsp_valid && rsp_ready in the same cycle that cmd_valid is high: the command is accepted on the following cycle (IDLE).

Optional Feature:
PTB2_MST_TIMEOUT_EN:
- Defined: a counter restarts at each VALID issue. If the handshake is not completed within TIMEOUT_CYCLES, the block drops all VALID/READY, sets rsp_err, and goes to RESP.
- Undefined: the block waits indefinitely and the counter logic is absent.

Decomposition:
Package ptb2_axi_pkg contains:
- Register offset localparams.
- AXI RESP codes (OKAY, SLVERR, DECERR).
- RESULT code localparams.
- State enum.

Sub-module ptb2_axi_lite_single_xfer:
- One-shot single-beat write/read engine with start/done/resp.
- The sequencer FSM drives it.

Test Plan:
1. a=1, b=2, c=1; slave returns RESULT=2'b01 and DATA_OUT=-1 -> WDATA sequence 0x1, 0x2, 0x1 to 0x79C00000/04/08; rsp_result=01, x1=x2=-1 (4'b1111), rsp_err=0.
2. a=1, b=1, c=-6 -> C write carries WDATA 32'hFFFFFFFA; RESULT=10; two READ_EN writes; rsp_x1=2, rsp_x2=-3.
3. RESULT=00 -> no READ_EN or DATA_OUT transactions; rsp after the RESULT read with x1=x2=0.
4. Slave randomly delays AWREADY/WREADY/ARREADY/B/R by 0..7 cycles, with AWREADY and WREADY on different cycles -> protocol checker clean; identical response values.
5. BRESP=2'b10 on the B write -> no C write issued; rsp_err=1; rsp_valid held until rsp_ready.
6. M_AXI_ARESET asserted for 1 cycle during RD_ROOT -> all VALIDs 0 next cycle; cmd_ready=1; a fresh command completes correctly.
